// File: rtl/rob_pkg.sv
// Shared reorder-buffer parameters and entry payload type.
// Provides REG_LEN, RF_SIZE_LOG and the default ROB_SIZE_LOG.
package rob_pkg;

  localparam int REG_LEN          = 32;
  localparam int RF_SIZE_LOG      = 5;
  localparam int ROB_SIZE_LOG_DEF = 2;

  typedef struct packed {
    logic                   wen;
    logic [RF_SIZE_LOG-1:0] rd;
    logic [REG_LEN-1:0]     data;
  } rob_payload_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrapping circular-buffer pointer with increment and clear.
// Ports: clk, rst (sync, active-high), clr, inc, ptr.
module rob_ptr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // Power-of-two depth: natural overflow wraps SIZE-1 -> 0.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/rob.sv
// In-order retiring reorder buffer (circular, ROB_SIZE entries).
// Ports: clk, rst (sync, active-high); alloc_* dispatch side;
//   wb_* result side; flush; commit_valid/rf_* retire side; count.
// Macro ROB_WB_BYPASS_EN: writeback to the head retires same cycle.
module rob
  import rob_pkg::*;
#(
  parameter int ROB_SIZE_LOG = ROB_SIZE_LOG_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc_valid,
  input  logic                    alloc_wen,
  input  logic [RF_SIZE_LOG-1:0]  alloc_rd,
  output logic                    alloc_ready,
  output logic [ROB_SIZE_LOG-1:0] alloc_tag,
  input  logic                    wb_valid,
  input  logic [ROB_SIZE_LOG-1:0] wb_tag,
  input  logic [REG_LEN-1:0]      wb_data,
  input  logic                    flush,
  output logic                    commit_valid,
  output logic                    rf_wen,
  output logic [RF_SIZE_LOG-1:0]  rf_rd,
  output logic [REG_LEN-1:0]      rf_data,
  output logic [ROB_SIZE_LOG:0]   count
);

  localparam int ROB_SIZE = 2 ** ROB_SIZE_LOG;
  localparam logic [ROB_SIZE_LOG:0] FULL =
    (ROB_SIZE_LOG + 1)'(ROB_SIZE);

  logic [ROB_SIZE-1:0]     valid_q;
  logic [ROB_SIZE-1:0]     done_q;
  rob_payload_t            pay_q [ROB_SIZE];
  logic [ROB_SIZE_LOG-1:0] head;
  logic [ROB_SIZE_LOG-1:0] tail;
  rob_payload_t            head_e;
  logic                    do_alloc;
  logic                    do_wb;
  logic                    do_commit;
  logic                    bypass;

  assign head_e      = pay_q[head];
  assign alloc_ready = count < FULL;
  assign alloc_tag   = tail;

  assign do_alloc = alloc_valid && alloc_ready
                 && !flush && !rst;
  assign do_wb    = wb_valid && valid_q[wb_tag]
                 && !done_q[wb_tag] && !flush && !rst;

`ifdef ROB_WB_BYPASS_EN
  // do_wb already implies the target is valid and not done.
  assign bypass = do_wb && (wb_tag == head);
`else
  assign bypass = 1'b0;
`endif

  assign do_commit = !rst && !flush && valid_q[head]
                  && (done_q[head] || bypass);

  always_comb begin
    commit_valid = 1'b0;
    rf_wen       = 1'b0;
    rf_rd        = '0;
    rf_data      = '0;
    if (do_commit) begin
      commit_valid = 1'b1;
      rf_wen       = head_e.wen;
      rf_rd        = head_e.rd;
      rf_data      = bypass ? wb_data : head_e.data;
    end
  end

  rob_ptr #(.W(ROB_SIZE_LOG)) u_head (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (do_commit),
    .ptr (head)
  );

  rob_ptr #(.W(ROB_SIZE_LOG)) u_tail (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (do_alloc),
    .ptr (tail)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
    end else if (do_alloc && !do_commit) begin
      count <= count + 1'b1;
    end else if (!do_alloc && do_commit) begin
      count <= count - 1'b1;
    end
  end

  // Tail slot is always free when allocating and the head is
  // occupied when committing, so these writes never collide.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      if (do_wb) begin
        done_q[wb_tag] <= 1'b1;
      end
      if (do_alloc) begin
        valid_q[tail] <= 1'b1;
        done_q[tail]  <= 1'b0;
      end
      if (do_commit) begin
        valid_q[head] <= 1'b0;
        done_q[head]  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_alloc) begin
      pay_q[tail].wen <= alloc_wen;
      pay_q[tail].rd  <= alloc_rd;
    end
    if (do_wb) begin
      pay_q[wb_tag].data <= wb_data;
    end
  end

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: directed scenarios plus random
// traffic against a queue-based model of in-order retirement.
module tb_rob;
  import rob_pkg::*;

  localparam int SZL = ROB_SIZE_LOG_DEF;
  localparam int SZ  = 1 << SZL;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   alloc_valid;
  logic                   alloc_wen;
  logic [RF_SIZE_LOG-1:0] alloc_rd;
  logic                   alloc_ready;
  logic [SZL-1:0]         alloc_tag;
  logic                   wb_valid;
  logic [SZL-1:0]         wb_tag;
  logic [REG_LEN-1:0]     wb_data;
  logic                   flush;
  logic                   commit_valid;
  logic                   rf_wen;
  logic [RF_SIZE_LOG-1:0] rf_rd;
  logic [REG_LEN-1:0]     rf_data;
  logic [SZL:0]           count;

  rob #(.ROB_SIZE_LOG(SZL)) dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_valid  (alloc_valid),
    .alloc_wen    (alloc_wen),
    .alloc_rd     (alloc_rd),
    .alloc_ready  (alloc_ready),
    .alloc_tag    (alloc_tag),
    .wb_valid     (wb_valid),
    .wb_tag       (wb_tag),
    .wb_data      (wb_data),
    .flush        (flush),
    .commit_valid (commit_valid),
    .rf_wen       (rf_wen),
    .rf_rd        (rf_rd),
    .rf_data      (rf_data),
    .count        (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     tag;
    bit     wen;
    int     rd;
    bit     done;
    longint data;
  } ent_t;

  ent_t q[$];
  int   tl;
  int   n_chk;
  int   n_pass;

  logic ob_cv, ob_wen, ob_ready;
  logic [RF_SIZE_LOG-1:0] ob_rd;
  logic [REG_LEN-1:0]     ob_data;
  logic [SZL-1:0]         ob_tag;
  logic [SZL:0]           ob_cnt;

  task automatic check(input string tag,
                       input longint got,
                       input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  tag, got, exp);
  endtask

  // One clock: drive at negedge, check outputs, advance model.
  task automatic step(input bit rs, input bit fl,
                      input bit av, input bit aw,
                      input int ard,
                      input bit wv, input int wt,
                      input longint wd);
    bit     e_cv, e_wen, e_rdy, hit;
    int     e_rd;
    longint e_data;
    @(negedge clk);
    rst         = rs;
    flush       = fl;
    alloc_valid = av;
    alloc_wen   = aw;
    alloc_rd    = RF_SIZE_LOG'(ard);
    wb_valid    = wv;
    wb_tag      = SZL'(wt);
    wb_data     = REG_LEN'(wd);
    #1;
    e_rdy  = q.size() < SZ;
    e_cv   = 0;
    e_wen  = 0;
    e_rd   = 0;
    e_data = 0;
    if (!rs && !fl && q.size() > 0) begin
      if (q[0].done) begin
        e_cv   = 1;
        e_data = q[0].data;
      end
`ifdef ROB_WB_BYPASS_EN
      else if (wv && wt == q[0].tag) begin
        e_cv   = 1;
        e_data = wd & 64'hFFFF_FFFF;
      end
`endif
      if (e_cv) begin
        e_wen = q[0].wen;
        e_rd  = q[0].rd;
      end
    end
    ob_cv    = commit_valid;
    ob_wen   = rf_wen;
    ob_rd    = rf_rd;
    ob_data  = rf_data;
    ob_ready = alloc_ready;
    ob_tag   = alloc_tag;
    ob_cnt   = count;
    check("commit_valid", longint'(ob_cv), longint'(e_cv));
    check("rf_wen", longint'(ob_wen), longint'(e_wen));
    check("rf_rd", longint'(ob_rd), longint'(e_rd));
    check("rf_data", longint'(ob_data), e_data);
    check("alloc_ready", longint'(ob_ready), longint'(e_rdy));
    check("alloc_tag", longint'(ob_tag), longint'(tl));
    check("count", longint'(ob_cnt), longint'(q.size()));
    if (rs || fl) begin
      q.delete();
      tl = 0;
    end else begin
      hit = 0;
      if (wv) begin
        foreach (q[i]) begin
          if (!hit && q[i].tag == wt && !q[i].done) begin
            q[i].done = 1;
            q[i].data = wd & 64'hFFFF_FFFF;
            hit = 1;
          end
        end
      end
      if (e_cv) void'(q.pop_front());
      if (av && e_rdy) begin
        q.push_back('{tl, aw, ard, 1'b0, 64'd0});
        tl = (tl + 1) % SZ;
      end
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alloc(input bit aw, input int ard);
    step(0, 0, 1, aw, ard, 0, 0, 0);
  endtask

  task automatic wb(input int wt, input longint wd);
    step(0, 0, 0, 0, 0, 1, wt, wd);
  endtask

  int t0, t1, ht;

  initial begin
    n_chk = 0;
    n_pass = 0;
    tl = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle();
    check("rst_ready", longint'(ob_ready), 1);
    check("rst_count", longint'(ob_cnt), 0);

    // single alloc / writeback / commit
    alloc(1, 3);
    wb(0, 64'h5A);
    idle();
    check("d36_cv", longint'(ob_cv), 1);
    check("d36_rd", longint'(ob_rd), 3);
    check("d36_data", longint'(ob_data), 64'h5A);
    check("d36_cnt1", longint'(ob_cnt), 1);
    idle();
    check("d36_cnt0", longint'(ob_cnt), 0);

    // out-of-order writeback, in-order commit
    t0 = tl;
    alloc(1, 7);
    t1 = tl;
    alloc(1, 9);
    wb(t1, 64'h11);
    idle();
    check("d37_no_ooo", longint'(ob_cv), 0);
    wb(t0, 64'h22);
    idle();
    check("d37_first", longint'(ob_rd), 7);
    idle();
    check("d37_second", longint'(ob_rd), 9);

    // fill, refuse alloc during commit, wrap
    for (int i = 0; i < SZ; i++) alloc(1, i + 1);
    idle();
    check("d38_full", longint'(ob_ready), 0);
    check("d38_cnt", longint'(ob_cnt), SZ);
    wb(q[0].tag, 64'h33);
    step(0, 0, 1, 1, 20, 0, 0, 0);
    check("d38_cv", longint'(ob_cv), 1);
    idle();
    check("d38_cnt2", longint'(ob_cnt), SZ - 1);
    alloc(1, 21);
    step(0, 1, 0, 0, 0, 0, 0, 0);

    // no-write instruction
    alloc(0, 0);
    wb(0, 64'h44);
    idle();
    check("d39_cv", longint'(ob_cv), 1);
    check("d39_wen", longint'(ob_wen), 0);

    // flush with pending work, stale writeback
    for (int i = 0; i < 3; i++) alloc(1, 4 + i);
    wb(0, 64'h55);
    step(0, 1, 1, 1, 1, 1, 1, 64'h66);
    check("d40_fl_wen", longint'(ob_wen), 0);
    wb(1, 64'h77);
    idle();
    check("d40_cnt", longint'(ob_cnt), 0);
    check("d40_cv", longint'(ob_cv), 0);
    alloc(1, 5);
    wb(0, 64'h88);
    step(1, 0, 1, 1, 2, 1, 1, 64'h99);
    check("d40_rst_wen", longint'(ob_wen), 0);
    idle();
    check("d40_rst_cnt", longint'(ob_cnt), 0);

    // writeback straight to the head
    alloc(1, 12);
    ht = q[0].tag;
    wb(ht, 64'h77);
`ifdef ROB_WB_BYPASS_EN
    check("d41_same", longint'(ob_cv), 1);
    check("d41_data", longint'(ob_data), 64'h77);
`else
    check("d41_same", longint'(ob_cv), 0);
    idle();
    check("d41_next", longint'(ob_cv), 1);
    check("d41_data", longint'(ob_data), 64'h77);
`endif

    // random traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 79) == 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 31)),
           $urandom_range(0, 2) != 0,
           int'($urandom_range(0, SZ - 1)),
           longint'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
